// File: rtl/wiggle_gpio_pkg.sv
// Shared definitions for the wiggle GPIO Wishbone register block:
// register byte offsets, the default ID constant, the decoded register
// select and a byte-lane merge helper.
package wiggle_gpio_pkg;

  localparam logic [4:0] REG_A_OUT      = 5'h00;
  localparam logic [4:0] REG_A_OE       = 5'h04;
  localparam logic [4:0] REG_A_TGL_MASK = 5'h08;
  localparam logic [4:0] REG_WIGGLE_DIV = 5'h0C;
  localparam logic [4:0] REG_B_IN       = 5'h10;
  localparam logic [4:0] REG_B_EDGE_ST  = 5'h14;
  localparam logic [4:0] REG_B_EDGE_MSK = 5'h18;
  localparam logic [4:0] REG_ID         = 5'h1C;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5749_4747;

  // Register select taken from address bits [4:2].
  typedef enum logic [2:0] {
    SEL_A_OUT  = REG_A_OUT[4:2],
    SEL_A_OE   = REG_A_OE[4:2],
    SEL_A_TGL  = REG_A_TGL_MASK[4:2],
    SEL_DIV    = REG_WIGGLE_DIV[4:2],
    SEL_B_IN   = REG_B_IN[4:2],
    SEL_B_STAT = REG_B_EDGE_ST[4:2],
    SEL_B_MASK = REG_B_EDGE_MSK[4:2],
    SEL_ID     = REG_ID[4:2]
  } reg_sel_e;

  // Replace the bytes of old_v enabled in sel with the bytes of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wiggle_gpio_wb_sync_edge.sv
// gpio_b input synchroniser (STAGES flops deep) followed by a per-bit
// rising-edge detector against the previous synchronised value.
module wiggle_sync_edge #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] prev_q;

  // Shift the asynchronous input through the chain; remember last sync value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/wiggle_gpio_wb.sv
// Wishbone B4 classic register slave for the wiggle design: drives gpio_a
// (static or self-timed toggling) and samples gpio_b with rising-edge
// status and a level interrupt.
// Optional build macro WIGGLE_GPIO_WB_ERR_EN: unmapped accesses and writes
// to read-only registers answer with wb_err_o instead of wb_ack_o.
module wiggle_gpio_wb
  import wiggle_gpio_pkg::*;
#(
  parameter int          GPIO_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int          DIV_W       = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [GPIO_W-1:0] gpio_a_o,
  output logic [GPIO_W-1:0] gpio_a_oe,
  input  logic [GPIO_W-1:0] gpio_b_i,
  output logic              irq_o
);

  logic [GPIO_W-1:0] a_out_q, a_out_d, a_oe_q, a_oe_d, tgl_q, tgl_d;
  logic [GPIO_W-1:0] stat_q, stat_d, emask_q, emask_d;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [31:0]       dat_q, dat_d, rd_val;
  logic              ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic              req, wr, tick, bad, unmapped;
  logic [GPIO_W-1:0] b_sync, b_rise;
  reg_sel_e          rsel;
  logic              unused_adr;

  wiggle_sync_edge #(.W(GPIO_W), .STAGES(SYNC_STAGES)) u_sync_edge (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (gpio_b_i),
    .sync_o (b_sync),
    .rise_o (b_rise)
  );

  if (ADDR_W > 5) begin : g_hi_adr
    assign unmapped = |wb_adr_i[ADDR_W-1:5];
  end else begin : g_no_hi_adr
    assign unmapped = 1'b0;
  end

  assign unused_adr = ^wb_adr_i[1:0];
  assign rsel       = reg_sel_e'(wb_adr_i[4:2]);
  // A response in flight blocks a new request so ack is a one-cycle pulse.
  assign req        = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);
  assign wr         = req & wb_we_i & ~unmapped;
  assign tick       = (div_q != '0) && (cnt_q == div_q);

`ifdef WIGGLE_GPIO_WB_ERR_EN
  assign bad = unmapped | (wb_we_i & ((rsel == SEL_B_IN) | (rsel == SEL_ID)));
`else
  assign bad = 1'b0;
`endif

  // Read multiplexer; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    if (!unmapped) begin
      case (rsel)
        SEL_A_OUT:  rd_val = 32'(a_out_q);
        SEL_A_OE:   rd_val = 32'(a_oe_q);
        SEL_A_TGL:  rd_val = 32'(tgl_q);
        SEL_DIV:    rd_val = 32'(div_q);
        SEL_B_IN:   rd_val = 32'(b_sync);
        SEL_B_STAT: rd_val = 32'(stat_q);
        SEL_B_MASK: rd_val = 32'(emask_q);
        SEL_ID:     rd_val = ID_VALUE;
        default:    rd_val = '0;
      endcase
    end
  end

  // Next state: wiggle tick first, then software writes override it; a new
  // edge is OR-ed in last so it survives a simultaneous W1C.
  always_comb begin
    a_out_d = a_out_q;
    a_oe_d  = a_oe_q;
    tgl_d   = tgl_q;
    div_d   = div_q;
    emask_d = emask_q;
    stat_d  = stat_q;
    dat_d   = dat_q;
    ack_d   = req & ~bad;
    err_d   = req & bad;
    irq_d   = |(stat_q & emask_q);
    if (tick) a_out_d = a_out_q ^ tgl_q;
    if (div_q == '0 || tick) cnt_d = '0;
    else                     cnt_d = cnt_q + DIV_W'(1);
    if (req && !wb_we_i) dat_d = bad ? '0 : rd_val;
    if (wr) begin
      case (rsel)
        SEL_A_OUT:  a_out_d = GPIO_W'(byte_merge(32'(a_out_q), wb_dat_i, wb_sel_i));
        SEL_A_OE:   a_oe_d  = GPIO_W'(byte_merge(32'(a_oe_q), wb_dat_i, wb_sel_i));
        SEL_A_TGL:  tgl_d   = GPIO_W'(byte_merge(32'(tgl_q), wb_dat_i, wb_sel_i));
        SEL_DIV: begin
          div_d = DIV_W'(byte_merge(32'(div_q), wb_dat_i, wb_sel_i));
          cnt_d = '0;
        end
        SEL_B_STAT: stat_d  = stat_q & ~GPIO_W'(byte_merge(32'h0, wb_dat_i, wb_sel_i));
        SEL_B_MASK: emask_d = GPIO_W'(byte_merge(32'(emask_q), wb_dat_i, wb_sel_i));
        default: ;
      endcase
    end
    stat_d = stat_d | b_rise;
  end

  // Register state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      a_out_q <= '0;
      a_oe_q  <= '0;
      tgl_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      stat_q  <= '0;
      emask_q <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      a_out_q <= a_out_d;
      a_oe_q  <= a_oe_d;
      tgl_q   <= tgl_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
      emask_q <= emask_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign gpio_a_o  = a_out_q;
  assign gpio_a_oe = a_oe_q;
  assign irq_o     = irq_q;

endmodule
